// File: rtl/controller_cmd_pkg.sv
// Shared definitions for the command UART transmitter.
//    uart_state_t    : transmitter FSM state encoding
//    UART_DATA_BITS  : payload bits per frame (8N1)
//    CLKS_PER_BIT_DEF: bit period for 50 MHz / 115200 baud
package controller_cmd_pkg;

   localparam int UART_DATA_BITS   = 8;
   localparam int CLKS_PER_BIT_DEF = 434;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } uart_state_t;

endpackage

// File: rtl/controller_cmd_fifo.sv
// Synchronous show-ahead FIFO for command bytes.
//    clk, reset : clock, synchronous active-high reset
//    push/wr_data: write strobe and data; ignored while full
//    pop        : consume head; ignored while empty
//    full/empty : occupancy flags from the registered count
//    count      : entries stored, 0..DEPTH
//    head       : oldest entry, valid whenever !empty
module controller_cmd_fifo #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 8,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Full is judged before any same-cycle pop, so a push into a full FIFO
   // is dropped even when the head leaves on that edge.
   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/controller_command_uart_tx.sv
// Command byte UART transmitter: buffers host bytes and sends each as 8N1.
//    clk, reset : clock, synchronous active-high reset
//    cmd_data/cmd_wr : byte and 1-cycle push strobe
//    cmd_ready  : FIFO not full
//    ovf_clr/overflow: sticky dropped-byte flag and its clear (set wins)
//    fifo_count : bytes queued, excluding the byte on the line
//    busy       : frame in progress or bytes queued
//    tx         : registered serial output, idle high
//
// state | meaning
// IDLE  | line idle, waiting for a queued byte
// START | start bit (0) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1); chains straight into START if more bytes wait
module controller_command_uart_tx
   import controller_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    cmd_data,
   input  logic                          cmd_wr,
   output logic                          cmd_ready,
   input  logic                          ovf_clr,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          tx
);

   uart_state_t state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             ovf_q, ovf_d;
   logic             pop;
   logic             full, empty;
   logic [7:0]       head;
   logic             period_end;

   controller_cmd_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (cmd_wr),
      .wr_data (cmd_data),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count),
      .head    (head)
   );

   assign period_end = (timer_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + CNT_W'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = head;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (period_end) begin
               timer_d = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (period_end) begin
               timer_d   = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(UART_DATA_BITS - 1)) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (period_end) begin
               timer_d = '0;
               if (!empty) begin
                  pop       = 1'b1;
                  shift_d   = head;
                  bit_cnt_d = '0;
                  state_d   = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // tx follows the current state one cycle later; every period shifts
      // equally, so frame length is unaffected.
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase

      if (cmd_wr && full) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ovf_q     <= ovf_d;
      end
   end

   assign tx        = tx_q;
   assign overflow  = ovf_q;
   assign cmd_ready = !full;
   assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_controller_command_uart_tx.sv
module tb_controller_command_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       reset;
   logic [7:0] cmd_data;
   logic       cmd_wr;
   logic       cmd_ready;
   logic       ovf_clr;
   logic       overflow;
   logic [2:0] fifo_count;
   logic       busy;
   logic       tx;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int frames_done = 0;

   logic [7:0] exp_q[$];
   int         start_cycles[$];

   controller_command_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .CNT_W        (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_data   (cmd_data),
      .cmd_wr     (cmd_wr),
      .cmd_ready  (cmd_ready),
      .ovf_clr    (ovf_clr),
      .overflow   (overflow),
      .fifo_count (fifo_count),
      .busy       (busy),
      .tx         (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one push strobe; bytes expected on the line go to the scoreboard.
   task automatic push_byte(input logic [7:0] b, input bit expect_frame);
      cmd_data = b;
      cmd_wr   = 1'b1;
      if (expect_frame) exp_q.push_back(b);
      tick();
      cmd_wr   = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", busy, 1'b0);
      repeat (3) tick();
   endtask

   // Frame monitor: sampling on falling edges, 1.5 cycles into each bit.
   bit         mon_active = 0;
   int         mon_cnt    = 0;
   logic [7:0] mon_byte;
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            mon_active = 0;
         end else if (!mon_active) begin
            if (tx === 1'b0) begin
               mon_active = 1;
               mon_cnt    = 0;
               start_cycles.push_back(cyc);
            end
         end else begin
            mon_cnt++;
         end
         if (mon_active && reset !== 1'b1) begin
            if (mon_cnt == CPB/2 - 1) check("start_bit", tx, 1'b0);
            for (int i = 1; i <= 8; i++) begin
               if (mon_cnt == CPB*i + CPB/2 - 1) mon_byte[i-1] = tx;
            end
            if (mon_cnt == 9*CPB + CPB/2 - 1) begin
               check("stop_bit", tx, 1'b1);
               if (exp_q.size() == 0) begin
                  check("sb_unexpected_frame", exp_q.size(), 1);
               end else begin
                  check("frame_byte", mon_byte, exp_q.pop_front());
               end
               frames_done++;
               mon_active = 0;
            end
         end
      end
   end

   initial begin
      logic [7:0] b;
      int         fd;

      reset    = 1'b1;
      cmd_data = 8'h00;
      cmd_wr   = 1'b0;
      ovf_clr  = 1'b0;

      // 1 reset
      tick();
      tick();
      reset = 1'b0;
      check("rst_tx", tx, 1'b1);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_fifo_count", fifo_count, 3'd0);
      repeat (2) tick();

      // 2 single byte, cycle-exact waveform
      b = 8'hA5;
      push_byte(b, 1);
      check("a5_count_after_push", fifo_count, 3'd1);
      tick();
      check("a5_tx_latency", tx, 1'b1);
      check("a5_busy_start", busy, 1'b1);
      for (int k = 0; k < FRAME; k++) begin
         logic eb;
         tick();
         if (k < CPB)            eb = 1'b0;
         else if (k < 9*CPB)     eb = b[(k-CPB)/CPB];
         else                    eb = 1'b1;
         check($sformatf("a5_tx_k%0d", k), tx, eb);
         check($sformatf("a5_busy_k%0d", k), busy, (k < FRAME - 1));
      end
      wait_idle(200);
      check("a5_sb_empty", exp_q.size(), 0);

      // 3 back-to-back frames, no gap between stop and next start
      start_cycles.delete();
      push_byte(8'h01, 1);
      push_byte(8'h02, 1);
      push_byte(8'h03, 1);
      wait_idle(500);
      check("b2b_sb_empty", exp_q.size(), 0);
      check("b2b_frames", start_cycles.size(), 3);
      if (start_cycles.size() == 3) begin
         check("b2b_gap1", start_cycles[1] - start_cycles[0], FRAME);
         check("b2b_gap2", start_cycles[2] - start_cycles[1], FRAME);
      end

      // 4 overflow: 5 accepted, 6th dropped
      push_byte(8'h10, 1);
      push_byte(8'h21, 1);
      push_byte(8'h32, 1);
      push_byte(8'h43, 1);
      push_byte(8'h54, 1);
      push_byte(8'h65, 0);
      check("ovf_set", overflow, 1'b1);
      check("ovf_cmd_ready", cmd_ready, 1'b0);
      check("ovf_count", fifo_count, 3'd4);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_cleared", overflow, 1'b0);

      // 5 push while full on the edge where STOP pops the next byte
      repeat (34) tick();
      check("full_pre_count", fifo_count, 3'd4);
      check("full_pre_ovf", overflow, 1'b0);
      push_byte(8'hEE, 0);
      check("full_pop_count", fifo_count, 3'd3);
      check("full_pop_ovf", overflow, 1'b1);
      check("full_pop_ready", cmd_ready, 1'b1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      wait_idle(1000);
      check("ovf_sb_empty", exp_q.size(), 0);

      // 6 reset during DATA bit 3
      push_byte(8'h11, 0);
      push_byte(8'h22, 0);
      repeat (16) tick();
      check("midrst_pre_count", fifo_count, 3'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_tx", tx, 1'b1);
      check("midrst_count", fifo_count, 3'd0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ready", cmd_ready, 1'b1);
      repeat (3) tick();
      check("midrst_tx_idle", tx, 1'b1);
      fd = frames_done;
      push_byte(8'h5A, 1);
      wait_idle(200);
      check("midrst_frames", frames_done - fd, 1);
      check("midrst_sb_empty", exp_q.size(), 0);
      check("final_tx_idle", tx, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
